// File: rtl/contador_param.sv
`default_nettype none
// ============================================================================
// Module   : contador_param
// Purpose  : Multi-channel pop counter. A registered req/idx read port is
//            serviced only while the system is idle.
//            Optional macro CONTADOR_CLR_ON_READ_EN: an in-range read clears
//            the channel it reads.
// Revision : 1.0 - initial release
// ============================================================================
module contador_param #(
  parameter int NCH = 5,
  parameter int CW  = 5,
  parameter int IW  = 3,
  parameter int SAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] pop,
  input  logic           idle,
  input  logic           req,
  input  logic [IW-1:0]  idx,
  output logic           valid,
  output logic [CW-1:0]  data_out,
  output logic           idx_err
);

  localparam logic [CW-1:0] c_MAX = '1;

  typedef enum logic [0:0] {
    S_COUNT = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_svc;
  logic [NCH-1:0]  w_hit;
  logic            w_inrange;
  logic [CW-1:0]   w_rd_data;
  logic [CW-1:0]   w_cnt [NCH];
  logic            r_valid;
  logic [CW-1:0]   r_data;
  logic            r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_COUNT;
    else       r_state <= w_state_nxt;
  end

  // The state reflects idle as seen on the previous edge, so a request is
  // served on the edge where idle falls but not on the one where it rises.
  always_comb begin
    w_state_nxt = r_state;
    w_svc       = 1'b0;
    if (idle) w_state_nxt = S_READY;
    else      w_state_nxt = S_COUNT;
    w_svc = (r_state == S_READY) && req;
  end

  always_comb begin
    w_hit     = '0;
    w_rd_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (idx == IW'(i)) begin
        w_hit[i]  = 1'b1;
        w_rd_data = w_cnt[i];
      end
    end
  end

  assign w_inrange = |w_hit;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [CW-1:0] r_cnt;
    logic          w_clr;

`ifdef CONTADOR_CLR_ON_READ_EN
    assign w_clr = w_svc & w_hit[g];
`else
    assign w_clr = 1'b0;
`endif

    // A clear and a pop on the same edge leave exactly one count.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt <= '0;
      end else if (w_clr) begin
        r_cnt <= pop[g] ? CW'(1) : '0;
      end else if (pop[g]) begin
        if (r_cnt == c_MAX) r_cnt <= (SAT != 0) ? c_MAX : '0;
        else                r_cnt <= r_cnt + CW'(1);
      end
    end

    assign w_cnt[g] = r_cnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else if (w_svc) begin
      r_valid <= 1'b1;
      r_data  <= w_rd_data;
      r_err   <= ~w_inrange;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end
  end

  assign valid    = r_valid;
  assign data_out = r_data;
  assign idx_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_contador_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_contador_param
// Purpose  : Self-checking bench for contador_param against a count-array
//            reference model. Honours CONTADOR_CLR_ON_READ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_contador_param;

  localparam int NCH   = 5;
  localparam int CW    = 5;
  localparam int IW    = 3;
  localparam int SAT   = 1;
  localparam int c_MAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NCH-1:0] pop = '0;
  logic           idle = 1'b0;
  logic           req = 1'b0;
  logic [IW-1:0]  idx = '0;
  logic           valid;
  logic [CW-1:0]  data_out;
  logic           idx_err;

  int nvec = 0;
  int nerr = 0;

  int            m_cnt [NCH];
  bit            m_ready = 1'b0;
  logic          e_valid = 1'b0;
  logic [CW-1:0] e_data = '0;
  logic          e_err = 1'b0;

  contador_param #(.NCH(NCH), .CW(CW), .IW(IW), .SAT(SAT)) u_dut (
    .clk(clk), .reset(reset), .pop(pop), .idle(idle), .req(req), .idx(idx),
    .valid(valid), .data_out(data_out), .idx_err(idx_err)
  );

  always #5 clk = ~clk;

  // Reference: apply one rising edge's worth of the counting and read rules.
  task automatic tick();
    int clr_ch;
    clr_ch = -1;
    if (reset) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_ready = 1'b0;
      e_valid = 1'b0; e_data = '0; e_err = 1'b0;
    end else begin
      if (m_ready && req) begin
        e_valid = 1'b1;
        if (int'(idx) < NCH) begin
          e_data = CW'(m_cnt[int'(idx)]);
          e_err  = 1'b0;
`ifdef CONTADOR_CLR_ON_READ_EN
          clr_ch = int'(idx);
`endif
        end else begin
          e_data = '0;
          e_err  = 1'b1;
        end
      end else begin
        e_valid = 1'b0;
        e_err   = 1'b0;
      end
      for (int i = 0; i < NCH; i++) begin
        if (i == clr_ch)     m_cnt[i] = pop[i] ? 1 : 0;
        else if (pop[i]) begin
          if (m_cnt[i] == c_MAX) m_cnt[i] = (SAT != 0) ? c_MAX : 0;
          else                   m_cnt[i] = m_cnt[i] + 1;
        end
      end
      m_ready = idle;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; pop = '0; idle = 1'b0; req = 1'b0; idx = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if (valid !== 1'b0 || data_out !== '0 || idx_err !== 1'b0) begin
      nerr++;
      $display("FAIL reset_state: valid=%b data=%0d err=%b, want 0/0/0", valid, data_out, idx_err);
    end
    pop = 5'b10101; idle = 1'b1;
    repeat (3) tick();
    req = 1'b1; idx = 3'd2;
    tick();
    req = 1'b0; pop = 5'b00011;
    #2 reset = 1'b1;
    #1;
    nvec++;
    if (valid !== 1'b0 || data_out !== '0 || idx_err !== 1'b0) begin
      nerr++;
      $display("FAIL async_reset: valid=%b data=%0d err=%b, want 0/0/0", valid, data_out, idx_err);
    end
    tick();
    reset = 1'b0; pop = '0; idle = 1'b1;
    tick();
    for (int c = 0; c < NCH; c++) begin
      req = 1'b1; idx = IW'(c);
      tick();
      nvec++;
      if (valid !== 1'b1 || data_out !== '0) begin
        nerr++;
        $display("FAIL reset_count ch%0d: valid=%b data=%0d, want 1/0", c, valid, data_out);
      end
    end
    req = 1'b0;
  endtask

  task automatic test_basic_count();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      pop = 5'b00001; tick();
      pop = '0;       tick();
    end
    pop = 5'b00010;
    repeat (4) tick();
    pop = '0; idle = 1'b1;
    tick();
    for (int c = 0; c < 2; c++) begin
      req = 1'b1; idx = IW'(c);
      tick();
      req = 1'b0;
      nvec++;
      if (valid !== 1'b1 || data_out !== CW'(4) || data_out !== e_data || idx_err !== 1'b0) begin
        nerr++;
        $display("FAIL basic_read ch%0d: valid=%b data=%0d err=%b, want 1/4/0", c, valid, data_out, idx_err);
      end
    end
  endtask

  task automatic test_idle_gating();
    do_reset();
    pop = 5'b00100; tick(); pop = '0;
    req = 1'b1; idx = 3'd2; idle = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      nvec++;
      if (valid !== 1'b0 || idx_err !== 1'b0) begin
        nerr++;
        $display("FAIL idle_gate cyc%0d: valid=%b err=%b, want 0/0", k, valid, idx_err);
      end
    end
    idle = 1'b1;
    tick();
    nvec++;
    if (valid !== 1'b0) begin
      nerr++;
      $display("FAIL idle_rise_edge: valid=%b, want 0", valid);
    end
    tick();
    nvec++;
    if (valid !== 1'b1 || data_out !== CW'(1)) begin
      nerr++;
      $display("FAIL idle_first_serve: valid=%b data=%0d, want 1/1", valid, data_out);
    end
    idle = 1'b0;
    tick();
    nvec++;
    if (valid !== 1'b1) begin
      nerr++;
      $display("FAIL idle_fall_edge: valid=%b, want 1", valid);
    end
    tick();
    req = 1'b0;
    nvec++;
    if (valid !== 1'b0 || data_out !== CW'(1)) begin
      nerr++;
      $display("FAIL idle_after_fall: valid=%b data=%0d, want 0/1 held", valid, data_out);
    end
  endtask

  task automatic test_simul_pop_read();
    logic [CW-1:0] want2;
`ifdef CONTADOR_CLR_ON_READ_EN
    want2 = CW'(1);
`else
    want2 = CW'(6);
`endif
    do_reset();
    pop = 5'b01000;
    repeat (5) tick();
    idle = 1'b1; pop = '0;
    tick();
    pop = 5'b01000; req = 1'b1; idx = 3'd3;
    tick();
    pop = '0;
    nvec++;
    if (valid !== 1'b1 || data_out !== CW'(5)) begin
      nerr++;
      $display("FAIL simul_read: valid=%b data=%0d, want 1/5", valid, data_out);
    end
    tick();
    req = 1'b0;
    nvec++;
    if (valid !== 1'b1 || data_out !== want2) begin
      nerr++;
      $display("FAIL simul_followup: valid=%b data=%0d, want 1/%0d", valid, data_out, want2);
    end
  endtask

  task automatic test_saturate();
    logic [CW-1:0] want;
    want = (SAT != 0) ? CW'(31) : CW'(1);
    do_reset();
    pop = 5'b10000;
    repeat (33) tick();
    pop = '0; idle = 1'b1;
    tick();
    req = 1'b1; idx = 3'd4;
    tick();
    req = 1'b0;
    nvec++;
    if (valid !== 1'b1 || data_out !== want || data_out !== e_data) begin
      nerr++;
      $display("FAIL boundary_33pops: valid=%b data=%0d, want 1/%0d", valid, data_out, want);
    end
  endtask

  task automatic test_all_channels();
    do_reset();
    pop = '1;
    repeat (3) tick();
    pop = '0; idle = 1'b1;
    tick();
    req = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      idx = IW'(c);
      tick();
      nvec++;
      if (valid !== 1'b1 || data_out !== CW'(3)) begin
        nerr++;
        $display("FAIL all_pop ch%0d: valid=%b data=%0d, want 1/3", c, valid, data_out);
      end
    end
    req = 1'b0;
  endtask

  task automatic test_out_of_range();
    do_reset();
    pop = 5'b00101;
    repeat (2) tick();
    pop = '0; idle = 1'b1;
    tick();
    req = 1'b1; idx = 3'd6;
    tick();
    nvec++;
    if (valid !== 1'b1 || idx_err !== 1'b1 || data_out !== '0) begin
      nerr++;
      $display("FAIL oor_idx6: valid=%b err=%b data=%0d, want 1/1/0", valid, idx_err, data_out);
    end
    idx = 3'd2;
    tick();
    req = 1'b0;
    nvec++;
    if (valid !== 1'b1 || idx_err !== 1'b0 || data_out !== CW'(2)) begin
      nerr++;
      $display("FAIL oor_unchanged: valid=%b err=%b data=%0d, want 1/0/2", valid, idx_err, data_out);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      pop  = NCH'($urandom);
      idle = ($urandom_range(0, 3) != 0);
      req  = ($urandom_range(0, 2) != 0);
      idx  = IW'($urandom_range(0, 7));
      tick();
      nvec++;
      if (valid !== e_valid || data_out !== e_data || idx_err !== e_err) begin
        nerr++;
        $display("FAIL random cyc%0d: valid=%b data=%0d err=%b, want %b/%0d/%b",
                 k, valid, data_out, idx_err, e_valid, e_data, e_err);
      end
    end
    req = 1'b0; pop = '0;
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_idle_gating();
    test_simul_pop_read();
    test_saturate();
    test_all_channels();
    test_out_of_range();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
